reg_file_core: RTL and testbench
================================

// Module: reg_file_core
// PURPOSE
// - File-register array downstream of the GPR write-control stage; it consumes writeCommand, the GPR write data and the STATUS write data.
// - Holds a 5-bit operand address latch, INDF/FSR indirection, STATUS, FSR, TMR0, the PORTA-C latches and GPRs 0x08-0x1F.
// - Drives the combinational operand read bus to the ALU and forwards PCL writes to the program counter.
// PARAMETERS
// - GPR_RESET   8'h00  reset value of GPRs 0x08-0x1F and PORTA-C latches
// - STAT_RESET  8'h18  STATUS reset value (TO=1, PD=1)
// PORTS
// - clk                 in   1  sole clock; all state updates on rising edge
// - rst_n               in   1  synchronous, active-low reset
// - writeCommand        in   3  [2] latch addr, [1] Q4 data write, [0] STATUS write
// - gprWriteDataIn      in   8  addr in [4:0] when [2]; write data when [1]
// - statusWriteDataIn   in   8  full STATUS image when [0]
// - instTick            in   1  one pulse per instruction cycle (TMR0 increment)
// - pclIn               in   8  current PC[7:0] for reads of addr 0x02
// - readDataOut         out  8  combinational read at effective address
// - statusOut           out  8  current STATUS register
// - fsrOut              out  8  current FSR (bits [7:5] read as 1)
// - pclWriteEn          out  1  one-cycle pulse on a Q4 write to 0x02
// - pclWriteData        out  8  data accompanying pclWriteEn
// - portAOut/portBOut/portCOut out 8 each  output latches at 0x05/0x06/0x07
// BEHAVIOUR
// - Reset (rst_n=0 at edge): addrLatch=0, FSR[4:0]=0, STATUS=STAT_RESET, TMR0=0, inhibit=0, GPR/ports=GPR_RESET.
// - Reset values of outputs: readDataOut=0 (INDF with FSR=0), statusOut=8'h18, fsrOut=8'hE0, pclWriteEn=0, ports=GPR_RESET.
// - Reset mid-instruction discards any pending write in that cycle.
// - Effective address: ea = (addrLatch==0) ? FSR[4:0] : addrLatch.
//   - ea==0 (INDF with FSR=0): read returns 8'h00 and writes are dropped.
// - Address map: 0x01 TMR0, 0x02 PCL (read=pclIn), 0x03 STATUS, 0x04 FSR, 0x05-07 ports, 0x08-1F GPR.
// - cmd[2]: addrLatch <= gprWriteDataIn[4:0] at the edge. No other state changes.
// - cmd[1]: the register at ea (computed with the pre-edge addrLatch) <= gprWriteDataIn.
//   - FSR write stores only bits [4:0].
//   - PCL write: no storage; pclWriteEn=1 with pclWriteData=gprWriteDataIn for exactly that cycle (registered, 1 cycle latency).
// - cmd[0]: STATUS <= statusWriteDataIn.
// - cmd[1] and cmd[0] together with ea==0x03: STATUS <= {gprWriteDataIn[7:3], statusWriteDataIn[2:0]}.
// - cmd[2] and cmd[1] together: the data write uses the old latch value; the latch updates on the same edge.
// - Read latency 0: readDataOut reflects register state after the last edge; read-after-write is visible next cycle.
// - TMR0 (when enabled):
//   - Increments by 1 mod 256 on each instTick (0xFF -> 0x00, no flag).
//   - A cmd[1] write to 0x01 loads the data and sets a 2-bit inhibit counter to 2.
//   - While inhibit != 0, each instTick decrements inhibit instead of incrementing TMR0.
//   - A write and an instTick in the same cycle: the write wins and inhibit=2.
// CONFIGURATION
// - TMR0_EN defined: TMR0 counter and inhibit logic present as above.
// - TMR0_EN undefined: no TMR0 storage; 0x01 reads 8'h00; writes to 0x01 are ignored; instTick is unused.
// TESTING
// - Reset: rst_n=0 for 1 cycle -> statusOut=8'h18, fsrOut=8'hE0, readDataOut=0, pclWriteEn=0.
// - cmd=3'b100 data 8'h0A, then cmd=3'b010 data 8'h5C -> next cycle readDataOut=8'h5C at addr 0x0A.
// - Indirect access:
//   - Write FSR(0x04)=8'h12, write 8'h77 via addr 0, latch addr 0x12 -> readDataOut=8'h77.
//   - With FSR=0, INDF write is dropped and reads 0.
// - STATUS merge: latch 0x03, cmd=3'b011, gpr=8'hE0, status=8'h05 -> statusOut=8'hE5.
// - PCL: latch 0x02, cmd=3'b010 data 8'h40 -> pclWriteEn=1 for one cycle with 8'h40; readDataOut=pclIn.
// - TMR0 (TMR0_EN): write 8'hFE, then 3 ticks -> 8'hFE, 8'hFE, 8'hFF; then 1 more tick -> 8'h00.

Source files
------------

// File: rtl/reg_file_core_if.sv
// reg_file_core_if: bus bundle between the GPR write-control stage / ALU side
// and the file-register array.
//   slave  modport : used by reg_file_core (consumes commands, drives reads)
//   master modport : used by the driving side (stage logic or testbench)
// Signals:
//   writeCommand[2:0]   [2] latch addr, [1] Q4 data write, [0] STATUS write
//   gprWriteDataIn[7:0] address (bits [4:0]) or write data
//   statusWriteDataIn   full STATUS image
//   instTick            one pulse per instruction cycle
//   pclIn               current PC[7:0]
//   readDataOut         combinational operand read
//   statusOut, fsrOut   current STATUS / FSR
//   pclWriteEn/Data     registered PCL write forward
//   portAOut/B/C        port output latches
interface reg_file_core_if;
  logic [2:0] writeCommand;
  logic [7:0] gprWriteDataIn;
  logic [7:0] statusWriteDataIn;
  logic       instTick;
  logic [7:0] pclIn;
  logic [7:0] readDataOut;
  logic [7:0] statusOut;
  logic [7:0] fsrOut;
  logic       pclWriteEn;
  logic [7:0] pclWriteData;
  logic [7:0] portAOut;
  logic [7:0] portBOut;
  logic [7:0] portCOut;

  modport slave (
    input  writeCommand, gprWriteDataIn, statusWriteDataIn, instTick, pclIn,
    output readDataOut, statusOut, fsrOut, pclWriteEn, pclWriteData,
           portAOut, portBOut, portCOut
  );

  modport master (
    output writeCommand, gprWriteDataIn, statusWriteDataIn, instTick, pclIn,
    input  readDataOut, statusOut, fsrOut, pclWriteEn, pclWriteData,
           portAOut, portBOut, portCOut
  );
endinterface

// File: rtl/reg_file_core.sv
// reg_file_core: file-register array (addr latch, INDF/FSR, TMR0, STATUS,
// PORTA-C latches, GPRs 0x08-0x1F). Drives the combinational operand read bus
// and forwards PCL writes to the program counter.
// Ports:
//   clk    sole clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    reg_file_core_if.slave (see interface file for signal list)
// Configuration:
//   TMR0_EN  define to include the TMR0 counter and its write inhibit;
//            when undefined, 0x01 reads 8'h00, writes are ignored and
//            instTick is unused.
module reg_file_core #(
  parameter logic [7:0] GPR_RESET  = 8'h00,
  parameter logic [7:0] STAT_RESET = 8'h18
) (
  input  logic            clk,
  input  logic            rst_n,
  reg_file_core_if.slave  bus
);

  localparam logic [4:0] ADDR_INDF   = 5'h00;
  localparam logic [4:0] ADDR_TMR0   = 5'h01;
  localparam logic [4:0] ADDR_PCL    = 5'h02;
  localparam logic [4:0] ADDR_STATUS = 5'h03;
  localparam logic [4:0] ADDR_FSR    = 5'h04;
  localparam logic [4:0] ADDR_PORTA  = 5'h05;
  localparam logic [4:0] ADDR_PORTB  = 5'h06;
  localparam logic [4:0] ADDR_PORTC  = 5'h07;
  localparam logic [4:0] ADDR_GPR_LO = 5'h08;

  logic [4:0] addrLatchR;
  logic [4:0] fsrR;
  logic [7:0] statusR;
  logic [7:0] portAR;
  logic [7:0] portBR;
  logic [7:0] portCR;
  logic [7:0] gprR [8:31];
  logic       pclWriteEnR;
  logic [7:0] pclWriteDataR;
  logic [7:0] tmr0ReadS;

  logic [4:0] eaS;
  logic       dataWrS;
  logic [7:0] readDataS;

  // Effective address: a latched address of 0 selects the FSR pointer (INDF)
  assign eaS     = (addrLatchR == ADDR_INDF) ? fsrR : addrLatchR;
  assign dataWrS = bus.writeCommand[1];

  // Operand address latch; a same-edge data write still uses the old value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addrLatchR <= 5'h00;
    end else if (bus.writeCommand[2]) begin
      addrLatchR <= bus.gprWriteDataIn[4:0];
    end else begin
      addrLatchR <= addrLatchR;
    end
  end

  // FSR: only the five implemented pointer bits are stored
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsrR <= 5'h00;
    end else if (dataWrS && (eaS == ADDR_FSR)) begin
      fsrR <= bus.gprWriteDataIn[4:0];
    end else begin
      fsrR <= fsrR;
    end
  end

  // STATUS: a simultaneous data write merges the upper bits with the flag bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      statusR <= STAT_RESET;
    end else if (dataWrS && (eaS == ADDR_STATUS) && bus.writeCommand[0]) begin
      statusR <= {bus.gprWriteDataIn[7:3], bus.statusWriteDataIn[2:0]};
    end else if (dataWrS && (eaS == ADDR_STATUS)) begin
      statusR <= bus.gprWriteDataIn;
    end else if (bus.writeCommand[0]) begin
      statusR <= bus.statusWriteDataIn;
    end else begin
      statusR <= statusR;
    end
  end

  // Port output latches
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      portAR <= GPR_RESET;
      portBR <= GPR_RESET;
      portCR <= GPR_RESET;
    end else if (dataWrS) begin
      case (eaS)
        ADDR_PORTA: portAR <= bus.gprWriteDataIn;
        ADDR_PORTB: portBR <= bus.gprWriteDataIn;
        ADDR_PORTC: portCR <= bus.gprWriteDataIn;
        default: begin
          portAR <= portAR;
          portBR <= portBR;
          portCR <= portCR;
        end
      endcase
    end else begin
      portAR <= portAR;
      portBR <= portBR;
      portCR <= portCR;
    end
  end

  // General purpose registers 0x08-0x1F
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 8; i < 32; i++) begin
        gprR[i] <= GPR_RESET;
      end
    end else if (dataWrS && (eaS >= ADDR_GPR_LO)) begin
      gprR[eaS] <= bus.gprWriteDataIn;
    end else begin
      gprR[eaS] <= gprR[eaS];
    end
  end

  // PCL writes are not stored here; they are forwarded one cycle later
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pclWriteEnR   <= 1'b0;
      pclWriteDataR <= 8'h00;
    end else if (dataWrS && (eaS == ADDR_PCL)) begin
      pclWriteEnR   <= 1'b1;
      pclWriteDataR <= bus.gprWriteDataIn;
    end else begin
      pclWriteEnR   <= 1'b0;
      pclWriteDataR <= pclWriteDataR;
    end
  end

`ifdef TMR0_EN
  logic [7:0] tmr0R;
  logic [1:0] inhibitR;

  // TMR0: a write loads the counter and suppresses the next two ticks
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmr0R    <= 8'h00;
      inhibitR <= 2'd0;
    end else if (dataWrS && (eaS == ADDR_TMR0)) begin
      tmr0R    <= bus.gprWriteDataIn;
      inhibitR <= 2'd2;
    end else if (bus.instTick && (inhibitR != 2'd0)) begin
      tmr0R    <= tmr0R;
      inhibitR <= inhibitR - 2'd1;
    end else if (bus.instTick) begin
      tmr0R    <= tmr0R + 8'd1;
      inhibitR <= inhibitR;
    end else begin
      tmr0R    <= tmr0R;
      inhibitR <= inhibitR;
    end
  end

  assign tmr0ReadS = tmr0R;
`else
  logic unusedInstTick;
  assign unusedInstTick = bus.instTick;
  assign tmr0ReadS      = 8'h00;
`endif

  // Combinational operand read at the effective address
  always_comb begin
    readDataS = 8'h00;
    case (eaS)
      ADDR_INDF:   readDataS = 8'h00;
      ADDR_TMR0:   readDataS = tmr0ReadS;
      ADDR_PCL:    readDataS = bus.pclIn;
      ADDR_STATUS: readDataS = statusR;
      ADDR_FSR:    readDataS = {3'b111, fsrR};
      ADDR_PORTA:  readDataS = portAR;
      ADDR_PORTB:  readDataS = portBR;
      ADDR_PORTC:  readDataS = portCR;
      default:     readDataS = gprR[eaS];
    endcase
  end

  assign bus.readDataOut  = readDataS;
  assign bus.statusOut    = statusR;
  assign bus.fsrOut       = {3'b111, fsrR};
  assign bus.pclWriteEn   = pclWriteEnR;
  assign bus.pclWriteData = pclWriteDataR;
  assign bus.portAOut     = portAR;
  assign bus.portBOut     = portBR;
  assign bus.portCOut     = portCR;

endmodule

// File: tb/tb_reg_file_core.sv
// tb_reg_file_core: directed-vector bench for reg_file_core with
// hand-computed expected values.
module tb_reg_file_core;

  logic clk;
  logic rst_n;
  int   passCnt;
  int   checkCnt;

  reg_file_core_if bus ();

  reg_file_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checkCnt++;
    if (obs === exp) begin
      passCnt++;
    end else begin
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, then sample 1 time unit after the edge
  task automatic step(input logic [2:0] cmd, input logic [7:0] gpr,
                      input logic [7:0] stat, input logic tick);
    bus.writeCommand      = cmd;
    bus.gprWriteDataIn    = gpr;
    bus.statusWriteDataIn = stat;
    bus.instTick          = tick;
    @(posedge clk);
    #1;
    bus.writeCommand      = 3'b000;
    bus.gprWriteDataIn    = 8'h00;
    bus.statusWriteDataIn = 8'h00;
    bus.instTick          = 1'b0;
  endtask

  initial begin
    passCnt               = 0;
    checkCnt              = 0;
    rst_n                 = 1'b0;
    bus.writeCommand      = 3'b000;
    bus.gprWriteDataIn    = 8'h00;
    bus.statusWriteDataIn = 8'h00;
    bus.instTick          = 1'b0;
    bus.pclIn             = 8'h3C;

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkVal("rst_status", bus.statusOut, 8'h18);
    checkVal("rst_fsr", bus.fsrOut, 8'hE0);
    checkVal("rst_read", bus.readDataOut, 8'h00);
    checkVal("rst_pclen", {7'd0, bus.pclWriteEn}, 8'h00);
    checkVal("rst_porta", bus.portAOut, 8'h00);

    // Direct GPR write / read
    step(3'b100, 8'h0A, 8'h00, 1'b0);
    step(3'b010, 8'h5C, 8'h00, 1'b0);
    checkVal("gpr_0a", bus.readDataOut, 8'h5C);

    // Port latch
    step(3'b100, 8'h06, 8'h00, 1'b0);
    step(3'b010, 8'hA5, 8'h00, 1'b0);
    checkVal("portb", bus.portBOut, 8'hA5);
    checkVal("porta_kept", bus.portAOut, 8'h00);

    // FSR keeps only bits [4:0]
    step(3'b100, 8'h04, 8'h00, 1'b0);
    step(3'b010, 8'hC9, 8'h00, 1'b0);
    checkVal("fsr_mask", bus.fsrOut, 8'hE9);

    // Indirect access through FSR
    step(3'b010, 8'h12, 8'h00, 1'b0);
    checkVal("fsr_12", bus.fsrOut, 8'hF2);
    step(3'b100, 8'h00, 8'h00, 1'b0);
    step(3'b010, 8'h77, 8'h00, 1'b0);
    checkVal("indf_read", bus.readDataOut, 8'h77);
    step(3'b100, 8'h12, 8'h00, 1'b0);
    checkVal("direct_12", bus.readDataOut, 8'h77);

    // INDF with FSR=0 drops the write and reads zero
    step(3'b100, 8'h04, 8'h00, 1'b0);
    step(3'b010, 8'h00, 8'h00, 1'b0);
    checkVal("fsr_zero", bus.fsrOut, 8'hE0);
    step(3'b100, 8'h00, 8'h00, 1'b0);
    step(3'b010, 8'hAB, 8'h00, 1'b0);
    checkVal("indf0_read", bus.readDataOut, 8'h00);
    step(3'b100, 8'h08, 8'h00, 1'b0);
    checkVal("gpr08_clean", bus.readDataOut, 8'h00);

    // Latch and write together: data goes to old address 0x08, latch -> 0x09
    step(3'b110, 8'h29, 8'h00, 1'b0);
    checkVal("lw_new_addr", bus.readDataOut, 8'h00);
    step(3'b100, 8'h08, 8'h00, 1'b0);
    checkVal("lw_old_addr", bus.readDataOut, 8'h29);

    // STATUS merge and plain STATUS write
    step(3'b100, 8'h03, 8'h00, 1'b0);
    step(3'b011, 8'hE0, 8'h05, 1'b0);
    checkVal("status_merge", bus.statusOut, 8'hE5);
    checkVal("status_read", bus.readDataOut, 8'hE5);
    step(3'b001, 8'h00, 8'h1C, 1'b0);
    checkVal("status_only", bus.statusOut, 8'h1C);

    // PCL read and forwarded write pulse
    step(3'b100, 8'h02, 8'h00, 1'b0);
    checkVal("pcl_read", bus.readDataOut, 8'h3C);
    step(3'b010, 8'h40, 8'h00, 1'b0);
    checkVal("pcl_en", {7'd0, bus.pclWriteEn}, 8'h01);
    checkVal("pcl_data", bus.pclWriteData, 8'h40);
    checkVal("pcl_read_after", bus.readDataOut, 8'h3C);
    step(3'b000, 8'h00, 8'h00, 1'b0);
    checkVal("pcl_en_drop", {7'd0, bus.pclWriteEn}, 8'h00);

    // TMR0 at address 0x01
    step(3'b100, 8'h01, 8'h00, 1'b0);
    step(3'b010, 8'hFE, 8'h00, 1'b0);
`ifdef TMR0_EN
    checkVal("tmr0_load", bus.readDataOut, 8'hFE);
    step(3'b000, 8'h00, 8'h00, 1'b1);
    checkVal("tmr0_inh1", bus.readDataOut, 8'hFE);
    step(3'b000, 8'h00, 8'h00, 1'b1);
    checkVal("tmr0_inh2", bus.readDataOut, 8'hFE);
    step(3'b000, 8'h00, 8'h00, 1'b1);
    checkVal("tmr0_inc", bus.readDataOut, 8'hFF);
    step(3'b000, 8'h00, 8'h00, 1'b1);
    checkVal("tmr0_wrap", bus.readDataOut, 8'h00);
    step(3'b010, 8'h10, 8'h00, 1'b1);
    checkVal("tmr0_wr_tick", bus.readDataOut, 8'h10);
    step(3'b000, 8'h00, 8'h00, 1'b1);
    checkVal("tmr0_wr_inh", bus.readDataOut, 8'h10);
`else
    checkVal("tmr0_absent", bus.readDataOut, 8'h00);
    step(3'b000, 8'h00, 8'h00, 1'b1);
    checkVal("tmr0_no_tick", bus.readDataOut, 8'h00);
`endif

    // Reset in the middle of a pending write discards it
    step(3'b100, 8'h0A, 8'h00, 1'b0);
    checkVal("pre_rst_0a", bus.readDataOut, 8'h5C);
    rst_n = 1'b0;
    step(3'b010, 8'h99, 8'h00, 1'b0);
    rst_n = 1'b1;
    checkVal("mid_rst_status", bus.statusOut, 8'h18);
    checkVal("mid_rst_portb", bus.portBOut, 8'h00);
    step(3'b100, 8'h0A, 8'h00, 1'b0);
    checkVal("mid_rst_0a", bus.readDataOut, 8'h00);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
